// File: rtl/dmem_bus_if_if.sv
// dmem_bus_if_if: request/response and external bus handshake bundle for dmem_bus_if.
// The bidirectional data bus is kept out of this bundle as a plain inout on the block,
// so the tristate resolution stays on a simple wire.
interface dmem_bus_if_if;
  // memory-access stage request
  logic        req_valid;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  // pipeline control / response
  logic        stall;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        misalign;
  logic        bus_err;
  // external data bus handshake
  logic [31:0] daddr;
  logic [1:0]  dsize;
  logic        dreq;
  logic        dwrite;
  logic        dready_n;
  logic        dbusy;

  modport master (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata,
    input  dready_n, dbusy,
    output stall, resp_valid, resp_rdata, misalign, bus_err,
    output daddr, dsize, dreq, dwrite
  );

  modport slave (
    output req_valid, req_write, req_funct3, req_addr, req_wdata,
    output dready_n, dbusy,
    input  stall, resp_valid, resp_rdata, misalign, bus_err,
    input  daddr, dsize, dreq, dwrite
  );
endinterface

// File: rtl/dmem_bus_if.sv
// dmem_bus_if: data-memory bus interface for the RV32I memory-access stage.
// Runs one load/store at a time over the daddr/dsize/dreq/dwrite/ddata bus,
// stalls the pipeline while a transaction is outstanding and returns the
// extended load result with a one-cycle resp_valid pulse.
// Optional feature: define DMEM_TIMEOUT_EN to abort an ACCESS after
// TIMEOUT_CYCLES cycles with bus_err=1; otherwise ACCESS waits forever.
module dmem_bus_if #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic          clk,
  input  logic          rst,
  dmem_bus_if_if.master bus,
  inout  wire  [31:0]   ddata
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] daddr_q, daddr_d;
  logic [1:0]  dsize_q, dsize_d;
  logic        dreq_q, dreq_d;
  logic        dwrite_q, dwrite_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        misalign_q, misalign_d;

`ifdef DMEM_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bus_err_q, bus_err_d;
`else
  localparam int unsigned UNUSED_TIMEOUT = TIMEOUT_CYCLES;
`endif

  logic        misaligned;
  logic        done;
  logic [31:0] load_data;

  // Copy the store operand onto every byte lane its size can occupy.
  function automatic logic [31:0] lane_replicate(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] r;
    case (f3[1:0])
      2'b00:   r = {4{wd[7:0]}};
      2'b01:   r = {2{wd[15:0]}};
      default: r = wd;
    endcase
    return r;
  endfunction

  // Pick the addressed byte/half out of the bus word and sign/zero-extend it.
  function automatic logic [31:0] extract_load(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = d[{off, 3'b000} +: 8];
    h = d[{off[1], 4'b0000} +: 16];
    case (f3[1:0])
      2'b00:   r = {{24{b[7] & ~f3[2]}}, b};
      2'b01:   r = {{16{h[15] & ~f3[2]}}, h};
      default: r = d;
    endcase
    return r;
  endfunction

  // A store ends on dbusy low, a load on dready_n low; the other strobe is ignored.
  assign done      = dwrite_q ? ~bus.dbusy : ~bus.dready_n;
  assign load_data = extract_load(funct3_q, daddr_q[1:0], ddata);

  // Alignment of the request currently presented by the pipeline.
  always_comb begin
    misaligned = 1'b0;
    case (bus.req_funct3[1:0])
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = bus.req_addr[0];
      default: misaligned = (bus.req_addr[1:0] != 2'b00);
    endcase
  end

  // Next-state and registered-output logic for IDLE -> ACCESS -> RESP.
  always_comb begin
    state_d      = state_q;
    daddr_d      = daddr_q;
    dsize_d      = dsize_q;
    dreq_d       = dreq_q;
    dwrite_d     = dwrite_q;
    wdata_d      = wdata_q;
    funct3_d     = funct3_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    misalign_d   = misalign_q;
`ifdef DMEM_TIMEOUT_EN
    cnt_d        = cnt_q;
    bus_err_d    = bus_err_q;
`endif
    case (state_q)
      S_IDLE: begin
        misalign_d = 1'b0;
`ifdef DMEM_TIMEOUT_EN
        bus_err_d  = 1'b0;
`endif
        if (bus.req_valid) begin
          if (misaligned) begin
            misalign_d   = 1'b1;
            resp_valid_d = 1'b1;
            resp_rdata_d = 32'd0;
            state_d      = S_RESP;
          end else begin
            daddr_d  = bus.req_addr;
            dsize_d  = bus.req_funct3[1:0];
            dwrite_d = bus.req_write;
            wdata_d  = lane_replicate(bus.req_funct3, bus.req_wdata);
            funct3_d = bus.req_funct3;
            dreq_d   = 1'b1;
`ifdef DMEM_TIMEOUT_EN
            cnt_d    = '0;
`endif
            state_d  = S_ACCESS;
          end
        end
      end
      S_ACCESS: begin
        if (done) begin
          dreq_d       = 1'b0;
          dwrite_d     = 1'b0;
          resp_valid_d = 1'b1;
          resp_rdata_d = dwrite_q ? 32'd0 : load_data;
          state_d      = S_RESP;
        end
`ifdef DMEM_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          dreq_d       = 1'b0;
          dwrite_d     = 1'b0;
          resp_valid_d = 1'b1;
          resp_rdata_d = 32'd0;
          bus_err_d    = 1'b1;
          state_d      = S_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      S_RESP: begin
        // req_valid here is the request just completed, so it is not re-accepted.
        misalign_d = 1'b0;
`ifdef DMEM_TIMEOUT_EN
        bus_err_d  = 1'b0;
`endif
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset drops the bus request asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      daddr_q      <= 32'd0;
      dsize_q      <= 2'b00;
      dreq_q       <= 1'b0;
      dwrite_q     <= 1'b0;
      wdata_q      <= 32'd0;
      funct3_q     <= 3'd0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      misalign_q   <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
      cnt_q        <= '0;
      bus_err_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      daddr_q      <= daddr_d;
      dsize_q      <= dsize_d;
      dreq_q       <= dreq_d;
      dwrite_q     <= dwrite_d;
      wdata_q      <= wdata_d;
      funct3_q     <= funct3_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      misalign_q   <= misalign_d;
`ifdef DMEM_TIMEOUT_EN
      cnt_q        <= cnt_d;
      bus_err_q    <= bus_err_d;
`endif
    end
  end

  assign bus.stall      = ((state_q == S_IDLE) && bus.req_valid) || (state_q == S_ACCESS);
  assign bus.daddr      = daddr_q;
  assign bus.dsize      = dsize_q;
  assign bus.dreq       = dreq_q;
  assign bus.dwrite     = dwrite_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.misalign   = misalign_q;
`ifdef DMEM_TIMEOUT_EN
  assign bus.bus_err    = bus_err_q;
`else
  assign bus.bus_err    = 1'b0;
`endif

  // The data bus is only driven during a write cycle.
  assign ddata = ((state_q == S_ACCESS) && dwrite_q) ? wdata_q : 32'bz;

endmodule
